// File: rtl/reg_dump_serializer.sv
// reg_dump_serializer
//   Debug read-out stage on the register file's offline read port. A start
//   pulse walks addresses 0..NUM_REGS-1, captures each read byte and streams
//   it out over a valid/ready byte interface.
//   Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum
//   byte after the last register byte.
//
// Handshake: a byte transfers on a rising edge where out_valid && out_ready.
//   Once out_valid is high it stays high, and out_data stays stable, until
//   that transfer happens. out_ready may change freely.
module reg_dump_serializer #(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] read_addr_offline,
  input  logic [DATA_WIDTH-1:0] read_data_offline,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SEND     = 3'd2,
    S_SEND_CHK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk;
`endif

  // The register file is addressed straight from the index register.
  assign read_addr_offline = idx;
  assign state_dbg         = state;

  // Dump sequencer; out_data doubles as the hold register, and all status
  // outputs are registered alongside the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          idx <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
          chk <= '0;
`endif
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          // Each byte reflects the register contents in this cycle only.
          out_data  <= read_data_offline;
`ifdef REG_DUMP_CHECKSUM_EN
          chk       <= chk ^ read_data_offline;
`endif
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Accumulator already holds every captured byte.
              out_data <= chk;
              state    <= S_SEND_CHK;
`else
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
`endif
            end else begin
              out_valid <= 1'b0;
              idx       <= idx + ADDR_WIDTH'(1);
              state     <= S_LOAD;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_SEND_CHK: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_serializer.md
# reg_dump_serializer

Debug read-out stage that sits directly downstream of the processor's register file on its offline read port. When `start` is pulsed, it walks every register address and drives `read_addr_offline`. It captures each `read_data_offline` byte and streams the bytes out over a valid/ready byte interface to a debug link (UART or scan FIFO). It never touches the datapath read ports or the write port, so the core keeps running while a dump is in progress.

## Interface
Parameters:
- `NUM_REGS`, 4, number of registers dumped, addresses 0..NUM_REGS-1.
- `ADDR_WIDTH`, 2, width of the register-file address; must satisfy 2^ADDR_WIDTH >= NUM_REGS.
- `DATA_WIDTH`, 8, register and output byte width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `read_addr_offline`  out  ADDR_WIDTH  address to the register file offline read port.
- `read_data_offline`  in  DATA_WIDTH  combinational read data returned for `read_addr_offline`.
- `out_data`  out  DATA_WIDTH  byte being offered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte this cycle.
- `busy`  out  1  a dump is in progress.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, LOAD, SEND, SEND_CHK (only with the checksum macro), DONE. Index counter `idx` is ADDR_WIDTH bits wide.
- IDLE:
  - `idx`=0.
  - `start`=1 -> LOAD.
  - `start`=0 -> stay in IDLE.
- LOAD:
  - `read_addr_offline`=`idx`.
  - At the clock edge, capture `read_data_offline` into the hold register, then -> SEND.
- SEND:
  - `out_valid`=1 and `out_data`=hold.
  - On `out_valid`&&`out_ready`: if `idx`==NUM_REGS-1, go -> SEND_CHK when enabled, otherwise -> DONE.
  - Otherwise on the handshake, `idx`+1 and -> LOAD.
  - Without the handshake, stay in SEND with `out_data` held stable.
- DONE: `done`=1 for exactly one cycle, then -> IDLE.
- `busy` = (state != IDLE).
- `start` is ignored while `busy` is high; there is no queuing.
- `read_addr_offline` drives `idx` in every state.
- Each byte reflects the register value in its own LOAD cycle. Writes by the core between LOADs are visible in later bytes; there is no atomic snapshot.
- `out_valid` must never drop without a handshake.
- `out_data` must not change while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values (asynchronous on `reset_n`=0):
  - state=IDLE, `idx`=0.
  - `read_addr_offline`=0, `out_data`=0.
  - `out_valid`=0, `busy`=0, `done`=0, checksum=0.
- Reset mid-dump aborts immediately. No `done` pulse is produced, and the partial stream is abandoned.
- Cycle numbering: `start` high in cycle 0.
  - Cycle 1: LOAD with address 0; `busy`=1 from here.
  - Cycle 2: first `out_valid`.
- With `out_ready` tied high:
  - One byte every 2 cycles: bytes in cycles 2, 4, 6, 8.
  - `done` in cycle 9 and IDLE in cycle 10.
  - With checksum: checksum byte in cycle 9, `done` in cycle 10.
- Back-pressure stretches SEND by one cycle for each cycle that `out_ready`=0; LOAD is never stretched.
- `start` held high continuously re-triggers on the cycle the block returns to IDLE, giving back-to-back dumps with one idle cycle between them.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined:
  - A DATA_WIDTH-bit XOR accumulator clears in IDLE and XORs in each captured byte at LOAD.
  - After the last register byte is accepted, SEND_CHK offers the accumulator on `out_data` with the same valid/ready rules, then -> DONE.
  - Stream length is NUM_REGS+1 bytes.
- `REG_DUMP_CHECKSUM_EN` undefined: SEND_CHK and the accumulator are absent, and the stream is NUM_REGS bytes.

## Test plan
- Reset, then registers = {0x11, 0x22, 0x33, 0x44}, `out_ready`=1, `start` pulsed in cycle 0 -> bytes 0x11, 0x22, 0x33, 0x44 in cycles 2, 4, 6, 8; `done` in cycle 9; `busy` high in cycles 1..9.
- Same registers with `REG_DUMP_CHECKSUM_EN` -> fifth byte 0x44 (0x11^0x22^0x33^0x44); `done` one cycle later.
- `out_ready` held low for 3 cycles on byte 1 -> `out_data`=0x22 stays stable with `out_valid` high the whole time; stream order is unchanged; `done` arrives 3 cycles late.
- Core writes 0x99 to register 3 during byte 0's SEND -> fourth byte is 0x99.
- `start` pulsed again while `busy` -> ignored: exactly 4 bytes and one `done`.
- `reset_n` asserted during byte 2's SEND -> outputs return to reset values immediately with no `done`; a new `start` then dumps from address 0.
